// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel receiver.
//   state_t             : receiver FSM states (IDLE waits for sync, SHIFT collects bits)
//   SIPO_WIDTH_DEFAULT  : default number of bits per serial word
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int SIPO_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/sipo_shreg.sv
// Shift register with selectable bit order for the serial receiver.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : empty the register (start of a new frame)
//   shift_en   : take si into the register this cycle
//   si         : serial data bit
//   word       : register contents with the current si already shifted in,
//                so the caller can capture a complete word on the last bit's edge
// WIDTH must be at least 2.
module sipo_shreg
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_WIDTH_DEFAULT,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             si,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] shifted;

    // MSB-first shifts left so the earliest bit ends in the top position;
    // LSB-first shifts right so the earliest bit ends in bit 0.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted = {data_q[WIDTH-2:0], si};
        end else begin
            shifted = {si, data_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        data_d = data_q;
        if (clear) begin
            data_d = '0;
        end else if (shift_en) begin
            data_d = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign word = shifted;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in / parallel-out receiver with valid/ready handoff and sticky overrun.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sync       : frame-start strobe, one cycle before the first data bit
//   si         : serial data, one bit per cycle while busy
//   ready      : consumer accepts q when high together with valid
//   clr_ovr    : clears the sticky overrun flag
//   q          : last completed parallel word
//   valid      : q holds a word not yet consumed
//   busy       : a frame is being collected
//   overrun    : a completed word replaced one that was never consumed
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_WIDTH_DEFAULT,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             si,
    input  logic             ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             valid_q;
    logic             valid_d;
    logic             overrun_q;
    logic             overrun_d;
    logic             shift_en;
    logic             last_bit;
    logic [WIDTH-1:0] word;

    // A sync always wins over shifting: it discards any partial word and the
    // si present in that cycle is not part of the new frame.
    assign shift_en = (state_q == SHIFT) && !sync;
    assign last_bit = shift_en && (cnt_q == CW'(WIDTH - 1));

    sipo_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (sync),
        .shift_en (shift_en),
        .si       (si),
        .word     (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
    end

    // Completion takes priority over consumption so a word finishing on the
    // same edge it is consumed keeps valid asserted with the new data.
    // A new overrun takes priority over clr_ovr.
    always_comb begin
        cnt_d     = cnt_q;
        q_d       = q_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (sync) begin
            cnt_d = '0;
        end else if (shift_en) begin
            cnt_d = last_bit ? '0 : cnt_q + CW'(1);
        end
        if (clr_ovr) begin
            overrun_d = 1'b0;
        end
        if (last_bit) begin
            q_d     = word;
            valid_d = 1'b1;
            if (valid_q && !ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            q_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign q       = q_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Testbench for sipo_rx: one MSB-first and one LSB-first instance share the
// same inputs and are compared every cycle against a frame-level reference
// model that keeps the received bits in a queue.
module tb_sipo_rx;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic sync;
   logic si;
   logic ready;
   logic clr_ovr;

   logic [W-1:0] q_m;
   logic         valid_m;
   logic         busy_m;
   logic         overrun_m;
   logic [W-1:0] q_l;
   logic         valid_l;
   logic         busy_l;
   logic         overrun_l;

   int nChecks = 0;
   int nFails  = 0;

   // Reference model state; index 0 is the MSB-first instance, 1 is LSB-first
   bit           modActive;
   bit           modBits[$];
   logic [W-1:0] modQ[2];
   bit           modValid[2];
   bit           modOvr[2];

   // Free-running clock
   always #5 clk = ~clk;

   sipo_rx #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
      .clk     (clk),
      .rst_n   (rst_n),
      .sync    (sync),
      .si      (si),
      .ready   (ready),
      .clr_ovr (clr_ovr),
      .q       (q_m),
      .valid   (valid_m),
      .busy    (busy_m),
      .overrun (overrun_m)
   );

   sipo_rx #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
      .clk     (clk),
      .rst_n   (rst_n),
      .sync    (sync),
      .si      (si),
      .ready   (ready),
      .clr_ovr (clr_ovr),
      .q       (q_l),
      .valid   (valid_l),
      .busy    (busy_l),
      .overrun (overrun_l)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Build a word from the collected bits: bit i of the frame sits at
   // position W-1-i when MSB-first and at position i when LSB-first
   function automatic logic [W-1:0] wordOf(input int inst);
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < W; i++) begin
         if (modBits[i]) begin
            w = w | (W'(1) << ((inst == 0) ? (W - 1 - i) : i));
         end
      end
      return w;
   endfunction

   // Clear the reference model to its reset state
   task automatic modelReset();
      modActive = 1'b0;
      modBits.delete();
      for (int k = 0; k < 2; k++) begin
         modQ[k]     = '0;
         modValid[k] = 1'b0;
         modOvr[k]   = 1'b0;
      end
   endtask

   // Advance the reference model by one clock edge using the current inputs
   task automatic modelEdge();
      bit done;
      done = 1'b0;
      if (sync) begin
         modBits.delete();
         modActive = 1'b1;
      end else if (modActive) begin
         modBits.push_back(si);
         if (modBits.size() == W) begin
            done      = 1'b1;
            modActive = 1'b0;
         end
      end
      for (int k = 0; k < 2; k++) begin
         if (clr_ovr) modOvr[k] = 1'b0;
         if (done) begin
            if (modValid[k] && !ready) modOvr[k] = 1'b1;
            modQ[k]     = wordOf(k);
            modValid[k] = 1'b1;
         end else if (modValid[k] && ready) begin
            modValid[k] = 1'b0;
         end
      end
      if (done) modBits.delete();
   endtask

   // Compare every output of both instances with the model
   task automatic compareAll(input string tag);
      checkOutput({tag, " q_msb"},   q_m,       modQ[0]);
      checkOutput({tag, " v_msb"},   valid_m,   modValid[0]);
      checkOutput({tag, " b_msb"},   busy_m,    modActive);
      checkOutput({tag, " o_msb"},   overrun_m, modOvr[0]);
      checkOutput({tag, " q_lsb"},   q_l,       modQ[1]);
      checkOutput({tag, " v_lsb"},   valid_l,   modValid[1]);
      checkOutput({tag, " b_lsb"},   busy_l,    modActive);
      checkOutput({tag, " o_lsb"},   overrun_l, modOvr[1]);
   endtask

   // Drive one cycle of inputs, let the edge happen, then check on the falling edge
   task automatic applyStimulus(input string tag, input bit s, input bit d, input bit r, input bit c);
      sync    = s;
      si      = d;
      ready   = r;
      clr_ovr = c;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      compareAll(tag);
   endtask

   // Sync followed by a 4-bit frame given first-bit-first as b[0..3]
   task automatic sendFrame(input string tag, input bit [0:3] b, input bit r);
      applyStimulus(tag, 1'b1, 1'b0, r, 1'b0);
      for (int i = 0; i < W; i++) begin
         applyStimulus(tag, 1'b0, b[i], r, 1'b0);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      sync    = 1'b0;
      si      = 1'b0;
      ready   = 1'b0;
      clr_ovr = 1'b0;
      modelReset();
      #1;
      compareAll("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Sync edge counts as edge 1; valid appears after the 4th data edge
      applyStimulus("lat_sync", 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("lat_busy", busy_m, 1'b1);
      applyStimulus("lat_b0", 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus("lat_b1", 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus("lat_b2", 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("lat_notyet", valid_m, 1'b0);
      applyStimulus("lat_b3", 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("lat_valid", valid_m, 1'b1);
      checkOutput("lat_q_msb", q_m, 4'b1001);
      checkOutput("lat_q_lsb", q_l, 4'b1001);
      checkOutput("lat_ovr", overrun_m, 1'b0);
      applyStimulus("lat_after", 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("lat_onecycle", valid_m, 1'b0);
      checkOutput("lat_qhold", q_m, 4'b1001);

      // Bit order
      sendFrame("order", 4'b1100, 1'b1);
      checkOutput("order_msb", q_m, 4'b1100);
      checkOutput("order_lsb", q_l, 4'b0011);
      applyStimulus("order_idle", 1'b0, 1'b0, 1'b1, 1'b0);

      // Back-to-back frames with no consumer: overrun, then clear it
      sendFrame("ovr_a", 4'b1001, 1'b0);
      sendFrame("ovr_b", 4'b0110, 1'b0);
      checkOutput("ovr_q", q_m, 4'b0110);
      checkOutput("ovr_v", valid_m, 1'b1);
      checkOutput("ovr_o", overrun_m, 1'b1);
      applyStimulus("ovr_clr", 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("ovr_cleared", overrun_m, 1'b0);
      checkOutput("ovr_vkeep", valid_m, 1'b1);

      // Completion on the same edge that consumes the previous word
      applyStimulus("cc_consume", 1'b0, 1'b0, 1'b1, 1'b0);
      sendFrame("cc_a", 4'b1010, 1'b0);
      applyStimulus("cc_sync", 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus("cc_b0", 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("cc_b1", 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus("cc_b2", 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("cc_b3", 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("cc_v", valid_m, 1'b1);
      checkOutput("cc_q", q_m, 4'b0101);
      checkOutput("cc_o", overrun_m, 1'b0);
      applyStimulus("cc_idle", 1'b0, 1'b0, 1'b1, 1'b0);

      // Re-sync mid-frame discards the partial word
      applyStimulus("rs_sync", 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus("rs_p0", 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus("rs_p1", 1'b0, 1'b0, 1'b1, 1'b0);
      sendFrame("rs_full", 4'b0111, 1'b1);
      checkOutput("rs_q", q_m, 4'b0111);
      applyStimulus("rs_idle", 1'b0, 1'b0, 1'b1, 1'b0);

      // Reset mid-frame, then bits without sync are ignored
      applyStimulus("rst_sync", 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus("rst_p0", 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus("rst_p1", 1'b0, 1'b1, 1'b1, 1'b0);
      rst_n = 1'b0;
      modelReset();
      #1;
      compareAll("rst_async");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus("rst_nosync", 1'b0, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("rst_v", valid_m, 1'b0);
      checkOutput("rst_q", q_m, 4'b0000);

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         bit s;
         s = modActive ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
         applyStimulus("rand", s, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 15) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter: WIDTH, default 4, number of bits per serial word.
REQ-002 Parameter: MSB_FIRST, default 1, 1 = first received bit lands in q[WIDTH-1]; 0 = first received bit lands in q[0].
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: sync  input  1  frame-start strobe; high for one cycle in the cycle before the first data bit.
REQ-006 Port: si  input  1  serial data in; one bit per clk while receiving.
REQ-007 Port: ready  input  1  consumer accepts q when high together with valid.
REQ-008 Port: clr_ovr  input  1  clears the sticky overrun flag.
REQ-009 Port: q  output  WIDTH  last completed parallel word.
REQ-010 Port: valid  output  1  q holds an unconsumed word.
REQ-011 Port: busy  output  1  frame in progress (state SHIFT).
REQ-012 Port: overrun  output  1  sticky; a completed word overwrote an unconsumed one.

Function
REQ-013 The FSM SHALL have two states: IDLE and SHIFT; busy = (state == SHIFT).
REQ-014 IDLE: sync=1 -> SHIFT with bit counter cleared to 0; si is ignored in that cycle.
REQ-015 SHIFT: each cycle SHALL sample si into the shift register and increment the counter (width clog2(WIDTH+1)).
REQ-016 The sample taken with counter == WIDTH-1 SHALL complete the frame: on that same edge q <= assembled word, valid <= 1, state <= IDLE.
REQ-017 Latency: valid SHALL rise on the edge following the WIDTH-th data cycle, i.e. WIDTH+1 edges after the sync edge.
REQ-018 Bit order: MSB_FIRST=1 shifts left (new bit in LSB); MSB_FIRST=0 shifts right (new bit in MSB).
REQ-019 Handshake: valid && ready at an edge SHALL clear valid unless a frame completes on that same edge.
REQ-020 Completion while valid=1 and ready=0 SHALL overwrite q, keep valid=1, and set overrun=1.
REQ-021 Completion with valid=1 and ready=1 on the same edge SHALL load the new word, keep valid=1, and leave overrun unchanged.
REQ-022 sync=1 while in SHIFT SHALL discard the partial word and restart at counter 0; q and valid are unaffected.
REQ-023 q SHALL change only on frame completion; it holds its value after consumption.
REQ-024 overrun SHALL stay 1 until clr_ovr=1; if clr_ovr and a new overrun coincide, overrun SHALL be 1.
REQ-025 Back-to-back frames: a sync in the cycle after completion SHALL be accepted with no gap cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, counter=0, shift register=0, q=0, valid=0, busy=0, overrun=0.
REQ-027 Reset mid-frame SHALL drop the partial word; after release the block SHALL wait for a fresh sync.

Structure
REQ-028 Package sipo_pkg SHALL hold the state enum (IDLE, SHIFT) and the WIDTH default constant.
REQ-029 The shift register with bit-order selection SHALL be the sub-module sipo_shreg.
REQ-030 sipo_rx SHALL hold the FSM, counter, output register and handshake logic.

Verification
REQ-031 sync pulse, then si = 1,0,0,1, ready=1 -> valid for 1 cycle, 5 edges after sync, q=4'b1001, overrun=0.
REQ-032 MSB_FIRST=0, same stream -> q=4'b1001 (palindrome); then si=1,1,0,0 -> q=4'b0011.
REQ-033 ready=0, frames 1001 then 0110 back-to-back -> q=4'b0110, valid=1, overrun=1; clr_ovr pulse -> overrun=0, valid=1.
REQ-034 sync, bits 1,0, second sync, bits 0,1,1,1 -> q=4'b0111; the partial word never appears.
REQ-035 rst_n low after 2 bits, release, bits without sync -> valid stays 0, q=0.
REQ-036 ready=1 held with completion coinciding with consumption of the previous word -> valid stays 1, new q, overrun=0.
